turfbus_master: RTL and testbench

//  TURF-side end of the TURFbus serial link: a WISHBONE classic slave that

---
 rtl/turfbus_master.sv | 219 +++++++++++++++++++++
 tb/tb_turfbus_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfbus_master.sv
// turfbus_master
// ---------------------------------------------------------------------------
// TURF-side end of the TURFbus serial link. A WISHBONE classic slave: each
// bus cycle becomes a request frame shifted out on TREQ_neg, one bit per
// clock. The SURF's response frame is then shifted in from SREQ_neg and
// turned into a one-cycle ack or err.
//
// Line coding: logical bit b is driven as ~b, so idle (logical 0) is high.
//   request  : start(1), we, adr, sel, [dat if we], [parity]
//   response : start(1), status(0 ok / 1 err), [dat if read], [parity]
//
// Build option: define TURFBUS_PARITY_EN to append one even-parity bit
// (over every bit after start) to both frames. A response parity error
// yields wbs_err_o and leaves wbs_dat_o unchanged.
//
// Ports
//   wbs_clk_i  link and bus clock          wbs_rst_i  async active-high reset
//   wbs_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i  WISHBONE request
//   wbs_dat_o  read data, valid with ack   wbs_ack_o/err_o  1-cycle status
//   wbs_rty_o  tied 0
//   TREQ_neg   request line (registered)   SREQ_neg  response line (input)
// ---------------------------------------------------------------------------
module turfbus_master #(
    parameter int ADR_WIDTH = 20,
    parameter int DAT_WIDTH = 32,
    parameter int SEL_WIDTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 wbs_clk_i,
    input  logic                 wbs_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [ADR_WIDTH-1:0] wbs_adr_i,
    input  logic [SEL_WIDTH-1:0] wbs_sel_i,
    input  logic [DAT_WIDTH-1:0] wbs_dat_i,
    output logic [DAT_WIDTH-1:0] wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic                 wbs_rty_o,
    output logic                 TREQ_neg,
    input  logic                 SREQ_neg
);

`ifdef TURFBUS_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int REQ_RD_LEN  = 2 + ADR_WIDTH + SEL_WIDTH + PAR_BITS;
    localparam int REQ_WR_LEN  = REQ_RD_LEN + DAT_WIDTH;
    // Response bits following the start bit.
    localparam int RSP_RD_BITS = 1 + DAT_WIDTH + PAR_BITS;
    localparam int RSP_WR_BITS = 1 + PAR_BITS;
    localparam int CNT_MAX     = (TIMEOUT > REQ_WR_LEN) ? TIMEOUT : REQ_WR_LEN;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] REQ_RD_LAST = CNT_W'(REQ_RD_LEN - 1);
    localparam logic [CNT_W-1:0] REQ_WR_LAST = CNT_W'(REQ_WR_LEN - 1);
    localparam logic [CNT_W-1:0] RSP_RD_CNT  = CNT_W'(RSP_RD_BITS);
    localparam logic [CNT_W-1:0] RSP_WR_CNT  = CNT_W'(RSP_WR_BITS);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;        // bits left to send / wait cycles / bits left to receive
    logic [REQ_WR_LEN-1:0]  req_sr;     // request bits still to go, MSB next
    logic [RSP_RD_BITS-2:0] rx_sr;
    logic [RSP_RD_BITS-1:0] rx_next;
    logic                   we_q;
    logic                   abandon;    // master dropped cyc while we were busy
    logic                   sreq_q;     // logical value of SREQ, registered once

    logic [REQ_WR_LEN-1:0]  frame_rd;
    logic [REQ_WR_LEN-1:0]  frame_wr;
    logic                   rsp_status;
    logic [DAT_WIDTH-1:0]   rsp_data;
    logic                   rsp_par_ok;
    logic                   live;
    logic                   wait_timeout;
    logic                   recv_last;
    logic                   fin_ack;
    logic                   fin_err;
    logic                   fin_load;

    assign wbs_rty_o = 1'b0;

    // Frames are left-aligned so the shifter always emits from its MSB;
    // a read frame is padded with zeros that are never sent.
`ifdef TURFBUS_PARITY_EN
    logic par_rd;
    logic par_wr;
    assign par_rd   = ^{wbs_we_i, wbs_adr_i, wbs_sel_i};
    assign par_wr   = par_rd ^ (^wbs_dat_i);
    assign frame_wr = {1'b1, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i, par_wr};
    assign frame_rd = {1'b1, wbs_we_i, wbs_adr_i, wbs_sel_i, par_rd, {DAT_WIDTH{1'b0}}};
`else
    assign frame_wr = {1'b1, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i};
    assign frame_rd = {1'b1, wbs_we_i, wbs_adr_i, wbs_sel_i, {DAT_WIDTH{1'b0}}};
`endif

    // rx_sr is cleared on entry to RECV, so bits above the received ones are
    // zero and the XOR over the whole vector is the parity of what arrived.
    assign rx_next    = {rx_sr, sreq_q};
    assign rsp_status = we_q ? rx_next[PAR_BITS] : rx_next[DAT_WIDTH+PAR_BITS];
    assign rsp_data   = rx_next[DAT_WIDTH+PAR_BITS-1:PAR_BITS];
`ifdef TURFBUS_PARITY_EN
    assign rsp_par_ok = ~(^rx_next);
`else
    assign rsp_par_ok = 1'b1;
`endif

    assign live         = wbs_cyc_i && !abandon;
    assign wait_timeout = (state == S_WAIT) && !sreq_q && (cnt == TMO_LAST);
    assign recv_last    = (state == S_RECV) && (cnt == CNT_ONE);

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fin_ack  = 1'b0;
        fin_err  = 1'b0;
        fin_load = 1'b0;
        if (wait_timeout) begin
            fin_err = live;
        end else if (recv_last) begin
            if (rsp_status || !rsp_par_ok) begin
                fin_err = live;
            end else begin
                fin_ack  = live;
                fin_load = live && !we_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_sr    <= '0;
            rx_sr     <= '0;
            we_q      <= 1'b0;
            abandon   <= 1'b0;
            sreq_q    <= 1'b0;
            TREQ_neg  <= 1'b1;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            sreq_q    <= ~SREQ_neg;
            wbs_ack_o <= fin_ack;
            wbs_err_o <= fin_err;
            if (fin_load) begin
                wbs_dat_o <= rsp_data;
            end
            if ((state == S_SEND || state == S_WAIT || state == S_RECV) && !wbs_cyc_i) begin
                abandon <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        // Start bit goes on the line now; the rest follows.
                        we_q     <= wbs_we_i;
                        req_sr   <= wbs_we_i ? (frame_wr << 1) : (frame_rd << 1);
                        cnt      <= wbs_we_i ? REQ_WR_LAST : REQ_RD_LAST;
                        TREQ_neg <= 1'b0;
                        abandon  <= 1'b0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt != '0) begin
                        TREQ_neg <= ~req_sr[REQ_WR_LEN-1];
                        req_sr   <= req_sr << 1;
                        cnt      <= cnt - CNT_ONE;
                    end else begin
                        TREQ_neg <= 1'b1;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sreq_q) begin
                        rx_sr <= '0;
                        cnt   <= we_q ? RSP_WR_CNT : RSP_RD_CNT;
                        state <= S_RECV;
                    end else if (wait_timeout) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RECV: begin
                    rx_sr <= rx_next[RSP_RD_BITS-2:0];
                    cnt   <= cnt - CNT_ONE;
                    if (recv_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // ack/err is high this cycle; stb is deliberately not
                    // sampled here so a held strobe cannot re-trigger.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turfbus_master.sv
`timescale 1ns/1ps
module tb_turfbus_master;

    localparam int ADR_W = 20;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int TMO   = 1023;
`ifdef TURFBUS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int REQ_RD = 2 + ADR_W + SEL_W + PAR;
    localparam int RSP_RD = 2 + DAT_W + PAR;
    localparam int MIN_RD_LAT = REQ_RD + 1 + RSP_RD + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cyc = 1'b0;
    logic             stb = 1'b0;
    logic             we  = 1'b0;
    logic [ADR_W-1:0] adr = '0;
    logic [SEL_W-1:0] sel = '0;
    logic [DAT_W-1:0] dat_w = '0;
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             err;
    logic             rty;
    logic             treq_neg;
    logic             sreq_neg = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    logic [DAT_W-1:0] model_dat = '0;

    turfbus_master #(
        .ADR_WIDTH(ADR_W), .DAT_WIDTH(DAT_W), .SEL_WIDTH(SEL_W), .TIMEOUT(TMO)
    ) dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_sel_i(sel), .wbs_dat_i(dat_w),
        .wbs_dat_o(dat_r), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
        .TREQ_neg(treq_neg), .SREQ_neg(sreq_neg)
    );

    always #5 clk = ~clk;

    // Count high cycles of ack/err so pulse width and spurious pulses show up.
    always @(negedge clk) begin
        if (ack === 1'b1) ack_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete bus transaction with the bench acting as the SURF.
    task automatic run_txn(input string name, input bit t_we, input logic [ADR_W-1:0] t_adr,
                           input logic [SEL_W-1:0] t_sel, input logic [DAT_W-1:0] t_dat,
                           input int ta, input bit silent, input bit rsp_err,
                           input logic [DAT_W-1:0] rsp_dat, input bit bad_par,
                           input int drop_at, input bit hold_stb);
        bit q[$];
        bit rq[$];
        logic [63:0] exp_v;
        logic [63:0] got_v;
        int a0, e0, len, k, ticks;
        bit par, live, exp_ack, exp_err, seen;
        a0 = ack_cnt;
        e0 = err_cnt;

        q.push_back(1'b1);
        q.push_back(t_we);
        for (int i = ADR_W - 1; i >= 0; i--) q.push_back(t_adr[i]);
        for (int i = SEL_W - 1; i >= 0; i--) q.push_back(t_sel[i]);
        if (t_we) for (int i = DAT_W - 1; i >= 0; i--) q.push_back(t_dat[i]);
        if (PAR != 0) begin
            par = 1'b0;
            for (int i = 1; i < q.size(); i++) par ^= q[i];
            q.push_back(par);
        end
        len = q.size();
        exp_v = '0;
        foreach (q[i]) exp_v = {exp_v[62:0], q[i]};

        vectors++;
        if (treq_neg !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_before_start: TREQ_neg=%b expected 1", name, treq_neg);
        end

        cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; sel = t_sel; dat_w = t_dat;
        tick();
        ticks = 1;
        vectors++;
        if (treq_neg !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start_latency: TREQ_neg=%b expected 0", name, treq_neg);
        end
        got_v = {63'b0, ~treq_neg};
        for (int i = 1; i < len; i++) begin
            if (i == drop_at) begin
                cyc = 1'b0; stb = 1'b0;
            end
            tick();
            ticks++;
            got_v = {got_v[62:0], ~treq_neg};
        end
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s frame: got %h expected %h", name, got_v, exp_v);
        end
        tick();
        ticks++;
        vectors++;
        if (treq_neg !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_after_frame: TREQ_neg=%b expected 1", name, treq_neg);
        end

        live = (drop_at < 0);
        seen = 1'b0;
        if (silent) begin
            k = 0;
            while (!seen && k < TMO + 8) begin
                tick(); ticks++; k++;
                if (ack === 1'b1 || err === 1'b1) seen = 1'b1;
            end
            vectors++;
            if (k != TMO) begin
                miscompares++;
                $display("FAIL %s timeout_cycles: got %0d expected %0d", name, k, TMO);
            end
        end else begin
            repeat (ta) begin tick(); ticks++; end
            rq.push_back(1'b1);
            rq.push_back(rsp_err);
            if (!t_we) for (int i = DAT_W - 1; i >= 0; i--) rq.push_back(rsp_dat[i]);
            if (PAR != 0) begin
                par = bad_par;
                for (int i = 1; i < rq.size(); i++) par ^= rq[i];
                rq.push_back(par);
            end
            foreach (rq[i]) begin
                sreq_neg = ~rq[i];
                tick(); ticks++;
            end
            sreq_neg = 1'b1;
            k = 0;
            while (!seen && k < 8) begin
                tick(); ticks++; k++;
                if (ack === 1'b1 || err === 1'b1) seen = 1'b1;
            end
        end

        exp_ack = live && !silent && !rsp_err && !bad_par;
        exp_err = live && (silent || rsp_err || bad_par);
        if (exp_ack && !t_we) model_dat = rsp_dat;

        if (exp_ack || exp_err) begin
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL %s response_seen: got none expected ack=%0b err=%0b", name, exp_ack, exp_err);
            end else if (dat_r !== model_dat) begin
                miscompares++;
                $display("FAIL %s dat_at_pulse: got %h expected %h", name, dat_r, model_dat);
            end
        end
        if (exp_ack && !t_we) begin
            vectors++;
            if (ticks < MIN_RD_LAT) begin
                miscompares++;
                $display("FAIL %s read_latency: got %0d expected >= %0d", name, ticks, MIN_RD_LAT);
            end
        end

        if (hold_stb) tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (3) tick();
        vectors++;
        if (treq_neg !== 1'b1) begin
            miscompares++;
            $display("FAIL %s no_retrigger: TREQ_neg=%b expected 1", name, treq_neg);
        end
        vectors++;
        if (ack_cnt - a0 != int'(exp_ack)) begin
            miscompares++;
            $display("FAIL %s ack_cycles: got %0d expected %0d", name, ack_cnt - a0, exp_ack);
        end
        vectors++;
        if (err_cnt - e0 != int'(exp_err)) begin
            miscompares++;
            $display("FAIL %s err_cycles: got %0d expected %0d", name, err_cnt - e0, exp_err);
        end
        vectors++;
        if (dat_r !== model_dat) begin
            miscompares++;
            $display("FAIL %s dat_after: got %h expected %h", name, dat_r, model_dat);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (treq_neg !== 1'b1 || ack !== 1'b0 || err !== 1'b0 || rty !== 1'b0 || dat_r !== '0) begin
            miscompares++;
            $display("FAIL %s: treq=%b ack=%b err=%b rty=%b dat=%h expected 1 0 0 0 0",
                     name, treq_neg, ack, err, rty, dat_r);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        @(negedge clk);
        rst = 1'b0;
        tick();
        model_dat = '0;
    endtask

    task automatic test_write();
        run_txn("write", 1'b1, 20'h12345, 4'hF, 32'hDEADBEEF, 2, 1'b0, 1'b0, '0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 20'h00010, 4'hF, '0, 0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, -1, 1'b0);
    endtask

    task automatic test_remote_err();
        run_txn("remote_err", 1'b0, 20'h00020, 4'h3, '0, 3, 1'b0, 1'b1, 32'h12345678, 1'b0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b0, 20'hABCDE, 4'h1, '0, 0, 1'b1, 1'b0, '0, 1'b0, -1, 1'b0);
        run_txn("after_timeout", 1'b1, 20'h00F0F, 4'hC, 32'h0BADCAFE, 1, 1'b0, 1'b0, '0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_cyc_drop();
        run_txn("cyc_drop", 1'b0, 20'h55555, 4'hA, '0, 1, 1'b0, 1'b0, 32'h11111111, 1'b0, 10, 1'b0);
        run_txn("after_drop", 1'b0, 20'h0AAAA, 4'h5, '0, 2, 1'b0, 1'b0, 32'h87654321, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 1'b1, 20'h00001, 4'h8, 32'hA5A5A5A5, 0, 1'b0, 1'b0, '0, 1'b0, -1, 1'b1);
        run_txn("b2b_1", 1'b0, 20'hFFFFF, 4'hF, '0, 0, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_txn($sformatf("rand_%0d", n), 1'($urandom_range(0, 1)), ADR_W'($urandom),
                    SEL_W'($urandom), DAT_W'($urandom), int'($urandom_range(0, 6)), 1'b0,
                    ($urandom_range(0, 3) == 0), DAT_W'($urandom), 1'b0, -1,
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_parity_err();
        run_txn("parity_err", 1'b0, 20'h13579, 4'h6, '0, 1, 1'b0, 1'b0, 32'hFEEDFACE, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 20'h2468A; sel = 4'hF; dat_w = 32'h13572468;
        tick();
        vectors++;
        if (treq_neg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_send start: TREQ_neg=%b expected 0", treq_neg);
        end
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_send_async");
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_dat = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset_released");
        run_txn("after_reset", 1'b0, 20'h00777, 4'h9, '0, 0, 1'b0, 1'b0, 32'h600DF00D, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_remote_err();
        test_timeout();
        test_cyc_drop();
        test_back_to_back();
        test_random();
`ifdef TURFBUS_PARITY_EN
        test_parity_err();
`endif
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
